// File: rtl/widths_struct_pkg.sv
// Shared constants and FSM state type for the two-byte frame unpacker.
package widths_struct_pkg;

    localparam int unsigned FRAME_BYTES = 2;
    localparam int unsigned A_W         = 8;
    localparam int unsigned B_W         = 4;
    localparam int unsigned FLAT_W      = A_W + B_W;

    typedef enum logic [1:0] {
        ST_B0,
        ST_B1,
        ST_OUT
    } state_t;

endpackage

// File: rtl/widths_struct_unpack.sv
// Unpacks a byte stream of 2-byte frames {a[7:0]}, {pad[3:0], b[3:0]} into fields.
// Optional pad checking is enabled by defining WIDTHS_STRUCT_UNPACK_PAD_CHECK_EN.
module widths_struct_unpack
    import widths_struct_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [A_W-1:0]    m_a,
    output logic [B_W-1:0]    m_b,
    output logic [FLAT_W-1:0] m_flat,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              pad_err
);

    state_t         state_q;
    state_t         state_d;
    logic [A_W-1:0] byte0_q;
    logic           s_fire;
    logic           m_fire;

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state_q)
            ST_B0: begin
                s_ready = 1'b1;
                if (s_valid) state_d = ST_B1;
            end
            ST_B1: begin
                s_ready = 1'b1;
                if (s_valid) state_d = ST_OUT;
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) state_d = ST_B0;
            end
            default: state_d = ST_B0;
        endcase
    end

    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_B0;
        else     state_q <= state_d;
    end

    // byte0 is staged separately so m_a keeps showing the previous frame
    // until the whole new frame has arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte0_q   <= '0;
            m_a       <= '0;
            m_b       <= '0;
            frame_cnt <= '0;
        end else begin
            if (s_fire && state_q == ST_B0) byte0_q <= s_data;
            if (s_fire && state_q == ST_B1) begin
                m_a <= byte0_q;
                m_b <= s_data[B_W-1:0];
            end
            if (m_fire) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign m_flat = {m_a, m_b};

`ifdef WIDTHS_STRUCT_UNPACK_PAD_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            pad_err <= 1'b0;
        else if (s_fire && state_q == ST_B1 && s_data[7:B_W] != '0)
            pad_err <= 1'b1;
    end
`else
    logic unused_pad;
    assign unused_pad = ^s_data[7:B_W];
    assign pad_err    = 1'b0;
`endif

endmodule

// File: tb/tb_widths_struct_unpack.sv
// Randomized and directed bench for widths_struct_unpack against a frame-level model.
module tb_widths_struct_unpack;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        m_ready;

    logic        s_ready,  s_ready2;
    logic [7:0]  m_a,      m_a2;
    logic [3:0]  m_b,      m_b2;
    logic [11:0] m_flat,   m_flat2;
    logic        m_valid,  m_valid2;
    logic [15:0] frame_cnt;
    logic [1:0]  frame_cnt2;
    logic        pad_err,  pad_err2;

    widths_struct_unpack dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_a(m_a), .m_b(m_b), .m_flat(m_flat), .m_valid(m_valid), .m_ready(m_ready),
        .frame_cnt(frame_cnt), .pad_err(pad_err)
    );

    widths_struct_unpack #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
        .m_a(m_a2), .m_b(m_b2), .m_flat(m_flat2), .m_valid(m_valid2), .m_ready(m_ready),
        .frame_cnt(frame_cnt2), .pad_err(pad_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level reference: bytes pair up into frames, one frame held at a time.
    bit          model_ok  = 0;
    bit          have_b0   = 0;
    bit          pend      = 0;
    logic [7:0]  b0_byte   = '0;
    logic [7:0]  cur_a     = '0;
    logic [3:0]  cur_b     = '0;
    int unsigned cnt       = 0;
    bit          pad_seen  = 0;
    int          delivered = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            check("s_ready",   32'(s_ready),   32'(!pend));
            check("m_valid",   32'(m_valid),   32'(pend));
            check("m_a",       32'(m_a),       32'(cur_a));
            check("m_b",       32'(m_b),       32'(cur_b));
            check("m_flat",    32'(m_flat),    32'({cur_a, cur_b}));
            check("frame_cnt", 32'(frame_cnt), cnt % 65536);
            check("pad_err",   32'(pad_err),   32'(pad_seen));
            check("s_ready2",  32'(s_ready2),  32'(!pend));
            check("m_valid2",  32'(m_valid2),  32'(pend));
            check("m_flat2",   32'({m_a2, m_b2, m_flat2}), 32'({cur_a, cur_b, cur_a, cur_b}));
            check("cnt2",      32'(frame_cnt2), cnt % 4);
            check("pad_err2",  32'(pad_err2),  32'(pad_seen));
        end
        if (rst) begin
            model_ok = 1; have_b0 = 0; pend = 0; b0_byte = '0;
            cur_a = '0; cur_b = '0; cnt = 0; pad_seen = 0;
        end else if (model_ok) begin
            if (pend && m_ready) begin
                pend = 0;
                cnt++;
                delivered++;
            end else if (!pend && s_valid) begin
                if (!have_b0) begin
                    b0_byte = s_data;
                    have_b0 = 1;
                end else begin
                    cur_a   = b0_byte;
                    cur_b   = s_data[3:0];
`ifdef WIDTHS_STRUCT_UNPACK_PAD_CHECK_EN
                    if (s_data[7:4] != 4'h0) pad_seen = 1;
`endif
                    have_b0 = 0;
                    pend    = 1;
                end
            end
        end
    end

    task automatic step(input logic r, input logic sv, input logic [7:0] sd, input logic mr);
        rst = r; s_valid = sv; s_data = sd; m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    int start;
    int cyc;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        @(posedge clk); #1;
        step(1, 0, 8'h00, 0);

        // single frame with downstream always ready
        step(0, 1, 8'hA5, 1);
        step(0, 1, 8'h03, 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);

        // back-pressure: frame held, next byte waits for the frame to leave
        step(0, 1, 8'h12, 0);
        step(0, 1, 8'h0C, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'h77, 0);
        step(0, 1, 8'h77, 1);
        step(0, 1, 8'h77, 1);
        step(0, 1, 8'h05, 0);
        step(0, 0, 8'h00, 1);

        // reset between byte0 and byte1 discards byte0
        step(0, 1, 8'h55, 1);
        step(1, 0, 8'h00, 1);
        step(0, 1, 8'h66, 1);
        step(0, 1, 8'h01, 1);
        step(0, 0, 8'h00, 1);

        // non-zero pad followed by clean frames
        step(0, 1, 8'h3C, 1);
        step(0, 1, 8'hF4, 0);
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 8'h81, 1);
            step(0, 1, 8'h02, 1);
            step(0, 0, 8'h00, 1);
        end

        // five back-to-back frames from reset to walk the 2-bit counter wrap
        step(1, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'(i * 17), 1);
            step(0, 1, 8'(i), 1);
            step(0, 1, 8'hEE, 1);
        end
        step(0, 0, 8'h00, 1);

        start = delivered;
        cyc   = 0;
        while (delivered - start < 1000 && cyc < 20000) begin
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            cyc++;
        end
        check("random_frames", 32'(delivered - start), 32'd1000);

        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/widths_struct_unpack.md
WIDTHS_STRUCT_UNPACK -- requirements
Module: widths_struct_unpack

Interface
REQ-001 Parameter: CNT_W, default 16, width of the delivered-frame counter (legal range 1..32).
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 s_data  input  8  byte stream carrying packed frames.
REQ-005 s_valid  input  1  s_data valid.
REQ-006 s_ready  output  1  block accepts s_data this cycle.
REQ-007 m_a  output  8  unpacked a field.
REQ-008 m_b  output  4  unpacked b field.
REQ-009 m_flat  output  12  packed view, {m_a, m_b} (a in [11:4], b in [3:0]).
REQ-010 m_valid  output  1  frame on m_a/m_b/m_flat valid.
REQ-011 m_ready  input  1  downstream accepts frame.
REQ-012 frame_cnt  output  CNT_W  count of frames delivered.
REQ-013 pad_err  output  1  sticky pad-violation flag.

Function
REQ-014 Frame = 2 bytes, in order: byte0 = a[7:0]; byte1 = {pad[3:0], b[3:0]}.
REQ-015 Byte transfer occurs when s_valid && s_ready on a rising edge; frame transfer occurs when m_valid && m_ready.
REQ-016 FSM states: ST_B0 (await byte0), ST_B1 (await byte1), ST_OUT (frame held).
REQ-017 Transitions: ST_B0 -> ST_B1 on byte transfer; ST_B1 -> ST_OUT on byte transfer; ST_OUT -> ST_B0 on frame transfer; otherwise hold.
REQ-018 s_ready = 1 in ST_B0 and ST_B1, 0 in ST_OUT (no skid; combinational from state only, never from m_ready).
REQ-019 m_valid = 1 exactly in ST_OUT; m_a/m_b/m_flat registered, stable while m_valid && !m_ready.
REQ-020 Latency: byte1 transferred at edge N -> m_valid high after edge N; earliest next byte0 transfer is at edge following the frame transfer edge.
REQ-021 s_data ignored when s_valid low or s_ready low; m_a/m_b hold the last frame when m_valid low.
REQ-022 frame_cnt increments by 1 on each frame transfer, wraps from 2^CNT_W-1 to 0.
REQ-023 Pad bits ignored for m_b.

Reset
REQ-024 On rst high at an edge: state = ST_B0, m_valid = 0, s_ready = 1 after that edge, m_a = 0, m_b = 0, m_flat = 0, frame_cnt = 0, pad_err = 0.
REQ-025 Reset mid-frame discards any captured byte0; the next accepted byte is treated as byte0.
REQ-026 rst has priority over every simultaneous handshake.

Configuration
REQ-027 Macro WIDTHS_STRUCT_UNPACK_PAD_CHECK_EN: when defined, pad_err is set at the byte1 transfer edge if pad != 4'h0 and stays set until rst; the frame is still delivered.
REQ-028 Without the macro, pad_err is constant 0 and no pad-compare logic exists.

Structure
REQ-029 Shared package widths_struct_pkg holds: the frame-byte count (2), the field widths A_W=8 and B_W=4, the FLAT_W=12 constant, and the state enum type.
REQ-030 No sub-module is needed; the block is a single FSM with datapath registers.

Verification
REQ-031 Bytes 0xA5, 0x03 with m_ready=1 -> m_a=0xA5, m_b=0x3, m_flat=0xA53, m_valid for 1 cycle, frame_cnt=1.
REQ-032 Bytes 0x12, 0x0C, m_ready=0 for 5 cycles -> outputs stable at 0x12C, s_ready=0 throughout, next byte 0x77 not taken until the cycle after m_ready=1.
REQ-033 Byte 0x55 accepted, then rst pulsed, then 0x66, 0x01 -> frame 0x661 delivered, 0x55 discarded.
REQ-034 CNT_W=2, five back-to-back frames -> frame_cnt sequence 1,2,3,0,1.
REQ-035 With the macro defined: byte1=0xF4 -> m_b=0x4, pad_err=1 and stays 1 across later clean frames until rst. Without the macro: same stimulus -> pad_err=0.
REQ-036 s_valid toggling randomly with m_ready random over 1000 frames -> every frame matches the reference model and no bytes are lost or duplicated.
